// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped 2-bit counters plus a tagged BTB,
// registered one-cycle lookup, one-cycle training, saturating mispredict counter.
module branch_predictor #(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic [31:0] mispredict_cnt
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = 30 - IW;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic [1:0]         ctr   [ENTRIES];
  logic [ENTRIES-1:0] bvalid;
  logic [TW-1:0]      btag  [ENTRIES];
  logic [29:0]        btgt  [ENTRIES];

  logic [IW-1:0] lk_idx, up_idx;
  logic [TW-1:0] lk_tag, up_tag;
  logic          lk_hit, up_hit, lk_taken_p0;
  logic [31:0]   lk_target_p0;
  logic          unused_low_bits;

  assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign lk_idx = lookup_pc[IW+1:2];
  assign lk_tag = lookup_pc[31:IW+2];
  assign up_idx = upd_pc[IW+1:2];
  assign up_tag = upd_pc[31:IW+2];

  assign lk_hit       = bvalid[lk_idx] && (btag[lk_idx] == lk_tag);
  assign up_hit       = bvalid[up_idx] && (btag[up_idx] == up_tag);
  assign lk_taken_p0  = lookup_valid && lk_hit && ctr[lk_idx][1];
  assign lk_target_p0 = lk_taken_p0 ? {btgt[lk_idx], 2'b00} : 32'd0;

  // p0 -> p1: registered prediction, reads pre-update table state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= 32'd0;
    end else begin
      pred_valid  <= lookup_valid;
      pred_taken  <= lk_taken_p0;
      pred_target <= lk_target_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
      bvalid         <= '0;
      mispredict_cnt <= 32'd0;
    end else if (upd_valid) begin
      if (upd_pred_taken != upd_taken) mispredict_cnt <= sat_inc32(mispredict_cnt);
      if (upd_taken) begin
        if (up_hit) begin
          ctr[up_idx] <= sat_inc2(ctr[up_idx]);
        end else begin
          ctr[up_idx]    <= 2'b10;
          bvalid[up_idx] <= 1'b1;
        end
      end else if (up_hit) begin
        ctr[up_idx] <= sat_dec2(ctr[up_idx]);
      end
    end
  end

  // BTB payload; a write racing reset is harmless because bvalid is cleared
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btag[up_idx] <= up_tag;
      btgt[up_idx] <= upd_target[31:2];
    end
  end
endmodule
